// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the N x N serial-I/O systolic multiplier.
package systolic_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCompute,
    StOutput
  } state_e;

  // Full-precision accumulator width for an N-term dot product of data_w operands.
  function automatic int unsigned default_acc_w(input int unsigned n, input int unsigned data_w);
    return 2 * data_w + $clog2(n);
  endfunction

  // Bits in one serial frame of an n x n matrix of elem_w-bit elements.
  function automatic int unsigned frame_bits(input int unsigned n, input int unsigned elem_w);
    return n * n * elem_w;
  endfunction

  // Feed cycles (3n-2) plus one settle cycle.
  function automatic int unsigned compute_cycles(input int unsigned n);
    return 3 * n - 1;
  endfunction

endpackage

// File: rtl/systolic_nxn_serial_io_pe.sv
// Output-stationary MAC cell: forwards a east and b south through registers and
// accumulates a*b into an ACC_W accumulator that wraps on overflow.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 18,
  parameter bit          SIGNED = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              hold_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [ACC_W-1:0]  acc_o
);

  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [2*DATA_W-1:0] a_x, b_x, prod;
  logic [ACC_W-1:0]    prod_x;

  // Extend operands to product width so the truncated product is exact, then widen.
  always_comb begin
    a_x    = {{DATA_W{SIGNED & a_i[DATA_W-1]}}, a_i};
    b_x    = {{DATA_W{SIGNED & b_i[DATA_W-1]}}, b_i};
    prod   = a_x * b_x;
    prod_x = {{(ACC_W-2*DATA_W){SIGNED & prod[2*DATA_W-1]}}, prod};
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    if (!hold_i) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = acc_q + prod_x;
    end
    if (clr_i) begin
      acc_d = '0;
    end
  end

  // Pipeline and accumulator state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_nxn_serial_io.sv
// N x N output-stationary systolic multiplier with bit-serial framed A/B input and
// bit-serial C output. Computes C = A*B or C += A*B.
module systolic_nxn_serial_io
  import systolic_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = default_acc_w(N, DATA_W),
  parameter bit          SIGNED = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic accum,
  input  logic A_in_serial_data,
  input  logic A_in_serial_valid,
  input  logic A_in_frame_sync,
  input  logic B_in_serial_data,
  input  logic B_in_serial_valid,
  input  logic B_in_frame_sync,
  output logic C_out_serial_data,
  output logic C_out_serial_valid,
  output logic C_out_frame_sync,
  output logic busy,
  output logic done,
  output logic err_frame
);

  localparam int unsigned NN        = N * N;
  localparam int unsigned FRAME_W   = frame_bits(N, DATA_W);
  localparam int unsigned OUT_BITS  = frame_bits(N, ACC_W);
  localparam int unsigned FEED_LAST = compute_cycles(N) - 1;
  localparam int unsigned CNT_W     = $clog2(OUT_BITS);
  localparam int unsigned RX_W      = $clog2(FRAME_W + 1);
  localparam int unsigned EL_W      = $clog2(NN);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                start_ok, pe_clr, pe_hold, load_out, out_last;

  // Receivers: index 0 is A, index 1 is B.
  logic [1:0]          rx_data, rx_valid, rx_sync;
  logic [FRAME_W-1:0]  mem_q [2];
  logic [FRAME_W-1:0]  mem_d [2];
  logic [RX_W-1:0]     rx_cnt_q [2];
  logic [RX_W-1:0]     rx_cnt_d [2];
  logic [1:0]          open_q, open_d, loaded_q, loaded_d, restart;

  logic [DATA_W-1:0]   a_el [NN];
  logic [DATA_W-1:0]   b_el [NN];
  logic [DATA_W-1:0]   west [N];
  logic [DATA_W-1:0]   north [N];
  logic [DATA_W-1:0]   a_fwd [N][N];
  logic [DATA_W-1:0]   b_fwd [N][N];
  logic [ACC_W-1:0]    acc [N][N];
  logic [OUT_BITS-1:0] c_flat;

  logic [OUT_BITS-1:0] out_sr_q, out_sr_d;
  logic busy_q, busy_d, done_q, done_d, valid_q, valid_d, sync_q, sync_d, err_q, err_d;

  assign rx_data  = {B_in_serial_data, A_in_serial_data};
  assign rx_valid = {B_in_serial_valid, A_in_serial_valid};
  assign rx_sync  = {B_in_frame_sync, A_in_frame_sync};

  // Frame receivers: shift bits in MSB-first; a new sync clears the loaded flag because
  // the store is being overwritten, and a sync inside an open frame flags an error.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      mem_d[c]    = mem_q[c];
      rx_cnt_d[c] = rx_cnt_q[c];
      open_d[c]   = open_q[c];
      loaded_d[c] = loaded_q[c];
      restart[c]  = 1'b0;
      if (state_q == StIdle && rx_valid[c] && (rx_sync[c] || open_q[c])) begin
        mem_d[c] = {mem_q[c][FRAME_W-2:0], rx_data[c]};
        if (rx_sync[c]) begin
          restart[c]  = open_q[c];
          rx_cnt_d[c] = RX_W'(1);
          open_d[c]   = 1'b1;
          loaded_d[c] = 1'b0;
        end else begin
          rx_cnt_d[c] = rx_cnt_q[c] + RX_W'(1);
        end
        if (rx_cnt_d[c] == RX_W'(FRAME_W)) begin
          rx_cnt_d[c] = '0;
          open_d[c]   = 1'b0;
          loaded_d[c] = 1'b1;
        end
      end
      if (out_last) begin
        loaded_d[c] = 1'b0;
      end
    end
  end

  // Receiver state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        mem_q[c]    <= '0;
        rx_cnt_q[c] <= '0;
      end
      open_q   <= '0;
      loaded_q <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        mem_q[c]    <= mem_d[c];
        rx_cnt_q[c] <= rx_cnt_d[c];
      end
      open_q   <= open_d;
      loaded_q <= loaded_d;
    end
  end

  // Element views of the stores; element 0 ([0][0]) arrived first so sits at the top.
  for (genvar e = 0; e < NN; e++) begin : g_el
    assign a_el[e] = mem_q[0][(NN-1-e)*DATA_W +: DATA_W];
    assign b_el[e] = mem_q[1][(NN-1-e)*DATA_W +: DATA_W];
  end

  // Sequencer next state: fixed-length compute phase, then a fixed-length shift-out.
  always_comb begin
    start_ok = (state_q == StIdle) && start && loaded_q[0] && loaded_q[1];
    state_d  = state_q;
    cnt_d    = cnt_q;
    pe_clr   = 1'b0;
    load_out = 1'b0;
    out_last = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StCompute;
          cnt_d   = '0;
          pe_clr  = !accum;
        end
      end
      StCompute: begin
        if (cnt_q == CNT_W'(FEED_LAST)) begin
          state_d  = StOutput;
          cnt_d    = '0;
          load_out = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StOutput: begin
        if (cnt_q == CNT_W'(OUT_BITS - 1)) begin
          state_d  = StIdle;
          cnt_d    = '0;
          out_last = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pe_hold = (state_q != StCompute);

  // Skewed edge feed: row i / column j sees element k = t - i (or t - j) at feed cycle t.
  always_comb begin : feed
    int k;
    k = 0;
    for (int i = 0; i < int'(N); i++) begin
      west[i]  = '0;
      north[i] = '0;
      k        = int'(cnt_q) - i;
      if (state_q == StCompute && k >= 0 && k < int'(N)) begin
        west[i]  = a_el[EL_W'(i * int'(N) + k)];
        north[i] = b_el[EL_W'(k * int'(N) + i)];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DATA_W-1:0] a_in, b_in;
      if (j == 0) begin : g_west
        assign a_in = west[i];
      end else begin : g_east
        assign a_in = a_fwd[i][j-1];
      end
      if (i == 0) begin : g_north
        assign b_in = north[j];
      end else begin : g_south
        assign b_in = b_fwd[i-1][j];
      end
      systolic_pe #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W),
        .SIGNED(SIGNED)
      ) u_pe (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (pe_clr),
        .hold_i(pe_hold),
        .a_i   (a_in),
        .b_i   (b_in),
        .a_o   (a_fwd[i][j]),
        .b_o   (b_fwd[i][j]),
        .acc_o (acc[i][j])
      );
      assign c_flat[(NN-1-(i*N+j))*ACC_W +: ACC_W] = acc[i][j];
    end
  end

  // Output shifter and registered status flags.
  always_comb begin
    out_sr_d = out_sr_q;
    if (load_out) begin
      out_sr_d = c_flat;
    end else if (state_q == StOutput) begin
      out_sr_d = {out_sr_q[OUT_BITS-2:0], 1'b0};
    end
    busy_d  = (state_d != StIdle);
    valid_d = (state_d == StOutput);
    sync_d  = load_out;
    done_d  = out_last;
    err_d   = |restart;
  end

  // Sequencer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      out_sr_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      sync_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_sr_q <= out_sr_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      sync_q   <= sync_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign C_out_serial_data  = out_sr_q[OUT_BITS-1];
  assign C_out_serial_valid = valid_q;
  assign C_out_frame_sync   = sync_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err_frame          = err_q;

endmodule

// File: tb/tb_systolic_nxn_serial_io.sv
// Bench for systolic_nxn_serial_io at default parameters (N=4, DATA_W=8, ACC_W=18, signed).
module tb_systolic_nxn_serial_io;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 18;
  localparam int NN = N * N;
  localparam int L  = NN * AW;

  typedef int mat_t [NN];

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, accum = 1'b0;
  logic a_d = 1'b0, a_v = 1'b0, a_s = 1'b0, b_d = 1'b0, b_v = 1'b0, b_s = 1'b0;
  logic c_d, c_v, c_s, busy, done, err_frame;

  always #5 clk = ~clk;

  systolic_nxn_serial_io #(
    .N(4), .DATA_W(8), .ACC_W(18), .SIGNED(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .accum(accum),
    .A_in_serial_data(a_d), .A_in_serial_valid(a_v), .A_in_frame_sync(a_s),
    .B_in_serial_data(b_d), .B_in_serial_valid(b_v), .B_in_frame_sync(b_s),
    .C_out_serial_data(c_d), .C_out_serial_valid(c_v), .C_out_frame_sync(c_s),
    .busy(busy), .done(done), .err_frame(err_frame)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state
  mat_t       mA, mB;
  logic [AW-1:0] c_prev [NN];
  logic [AW-1:0] c_exp [NN];
  bit         exp_bits [L];
  bit         a_ld = 0, b_ld = 0, run_on = 0;
  int         run_k = 0, exp_err_cyc = -1;
  int         n_cmp = 0, n_bad = 0, first_cyc = -1, err_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // C = A*B (+ previous C), wrapped to AW bits, then serialised row-major MSB-first.
  task automatic compute_model(input bit acc);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int s;
        s = acc ? int'(c_prev[i*N+j]) : 0;
        for (int k = 0; k < N; k++) s += sx(mA[i*N+k]) * sx(mB[k*N+j]);
        c_exp[i*N+j] = AW'(s);
      end
    end
    for (int e = 0; e < NN; e++) begin
      c_prev[e] = c_exp[e];
      for (int b = 0; b < AW; b++) exp_bits[e*AW + b] = c_exp[e][AW-1-b];
    end
  endtask

  // Per-cycle compare of every output against the model's schedule.
  always @(negedge clk) begin
    bit eb, ed, ev, es, edat, ee;
    int d, m;
    eb = 0; ed = 0; ev = 0; es = 0; edat = 0;
    if (!rst) begin
      if (run_on) begin
        d  = cyc - run_k;
        m  = d - 3 * N;
        eb = (d >= 1) && (d <= 3 * N - 1 + L);
        ev = (m >= 0) && (m < L);
        es = (m == 0);
        if (ev) edat = exp_bits[m];
        ed = (d == 3 * N + L);
      end
      ee = (cyc == exp_err_cyc);
      chk($sformatf("outputs@%0d {busy,done,valid,sync,data,err}", cyc),
          {26'd0, busy, done, c_v, c_s, c_d, err_frame}, {26'd0, eb, ed, ev, es, edat, ee});
    end
    if (c_v && c_s) first_cyc = cyc;
    if (err_frame) err_cnt++;
  end

  function automatic logic bit_of(input mat_t m, input int i);
    return logic'((m[i / DW] >> (DW - 1 - i % DW)) & 1);
  endfunction

  task automatic drive_bit(input bit is_b, input logic d, input logic s);
    @(posedge clk); #1;
    if (is_b) begin b_v = 1; b_d = d; b_s = s; end
    else      begin a_v = 1; a_d = d; a_s = s; end
  endtask

  // Send a full frame; cut > 0 first sends a partial frame of that many bits.
  task automatic send_frame(input bit is_b, input mat_t m, input int cut);
    for (int i = 0; i < cut; i++) drive_bit(is_b, bit_of(m, i), logic'(i == 0));
    for (int i = 0; i < NN * DW; i++) begin
      drive_bit(is_b, bit_of(m, i), logic'(i == 0));
      if (cut > 0 && i == 0) exp_err_cyc = cyc + 1;
    end
    @(posedge clk); #1;
    if (is_b) begin b_v = 0; b_s = 0; b_d = 0; mB = m; b_ld = 1; end
    else      begin a_v = 0; a_s = 0; a_d = 0; mA = m; a_ld = 1; end
  endtask

  task automatic do_start(input bit acc);
    @(posedge clk); #1;
    start = 1; accum = acc;
    if ((!run_on || (cyc - run_k) >= 3 * N + L) && a_ld && b_ld) begin
      compute_model(acc);
      run_on = 1; run_k = cyc; a_ld = 0; b_ld = 0;
    end
    @(posedge clk); #1;
    start = 0; accum = 0;
  endtask

  task automatic wait_done(output int at);
    bit seen;
    seen = 0; at = -1;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; at = cyc; end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL wait_done: got no done expected done within 400 cycles");
    end
  endtask

  task automatic load_both(input mat_t ma, input mat_t mb, input int cut_a);
    fork
      send_frame(0, ma, cut_a);
      send_frame(1, mb, 0);
    join
  endtask

  initial begin
    mat_t ma, mb;
    int at;
    bit reached;
    for (int e = 0; e < NN; e++) c_prev[e] = '0;

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_outputs", {26'd0, busy, done, c_v, c_s, c_d, err_frame}, 32'd0);

    // Identity times ramp
    for (int e = 0; e < NN; e++) begin ma[e] = (e / N == e % N) ? 1 : 0; mb[e] = e + 1; end
    load_both(ma, mb, 0);
    do_start(0);
    for (int e = 0; e < NN; e++) chk($sformatf("model_identity[%0d]", e), c_exp[e], e + 1);
    wait_done(at);
    chk("first_bit_cycle", first_cyc, run_k + 12);
    chk("done_cycle", at, run_k + 300);

    // Signed: -1 * 2 summed over 4 terms
    for (int e = 0; e < NN; e++) begin ma[e] = 8'hFF; mb[e] = 8'h02; end
    load_both(ma, mb, 0);
    do_start(0);
    chk("model_signed", c_exp[7], 32'h3FFF8);
    wait_done(at);

    // Accumulate: 4 then 8
    for (int e = 0; e < NN; e++) begin ma[e] = 1; mb[e] = 1; end
    load_both(ma, mb, 0);
    do_start(0);
    chk("model_accum0", c_exp[0], 4);
    wait_done(at);
    load_both(ma, mb, 0);
    do_start(1);
    chk("model_accum1", c_exp[15], 8);
    wait_done(at);

    // Gating: A only, start must be ignored
    for (int e = 0; e < NN; e++) begin ma[e] = 3; mb[e] = 16 - e; end
    send_frame(0, ma, 0);
    do_start(0);
    repeat (20) @(negedge clk);
    chk("gated_busy", {31'd0, busy}, 32'd0);
    send_frame(1, mb, 0);
    do_start(0);
    chk("model_gated", c_exp[0], 3 * (16 + 12 + 8 + 4));
    wait_done(at);

    // Frame restart on A after 37 bits
    err_cnt = 0;
    for (int e = 0; e < NN; e++) begin ma[e] = (e * 37 + 5) % 256; mb[e] = (e * 11 + 200) % 256; end
    load_both(ma, mb, 37);
    chk("err_pulses", err_cnt, 1);
    do_start(0);
    wait_done(at);

    // Reset during OUTPUT at bit 100, then a fresh run with accum=1 over cleared C
    for (int e = 0; e < NN; e++) begin ma[e] = (e / N == e % N) ? 1 : 0; mb[e] = 16 - e; end
    load_both(ma, mb, 0);
    do_start(0);
    reached = 0;
    for (int i = 0; i < 400 && !reached; i++) begin
      @(posedge clk); #1;
      if (cyc == run_k + 3 * N + 100) reached = 1;
    end
    chk("reached_bit100", {31'd0, reached}, 32'd1);
    rst = 1;
    run_on = 0; a_ld = 0; b_ld = 0;
    for (int e = 0; e < NN; e++) c_prev[e] = '0;
    @(posedge clk); #1 rst = 0;
    repeat (5) @(negedge clk);
    load_both(ma, mb, 0);
    do_start(1);
    chk("model_after_reset", c_exp[0], 16);
    wait_done(at);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
